// File: rtl/rom_fetch_pkg.sv
// Shared definitions for the ROM burst fetcher: default widths and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package rom_fetch_pkg;

   localparam int AW_DEF    = 14;  // ROM address width
   localparam int DW_DEF    = 24;  // ROM data width
   localparam int DEPTH_DEF = 4;   // output buffer entries

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/rom_fetch_fifo.sv
// Output buffer for fetched ROM words: DEPTH x DW FIFO, head entry shown on o_dout.
// Latency: a pushed word is visible on o_dout the cycle after the push edge.
// Backpressure: caller guarantees no push when full and no pop when empty.
// Ports: CK/reset clock and async active-low reset; i_push/i_push_dat write side;
//        i_pop read side; o_dout head word (0 when empty), o_valid, o_count occupancy.
module rom_fetch_fifo
   import rom_fetch_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     CK,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [DW-1:0]            i_push_dat,
   input  logic                     i_pop,
   output logic [DW-1:0]            o_dout,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0]  r_mem [DEPTH];
   logic [PW-1:0]  r_wr;
   logic [PW-1:0]  r_rd;
   logic [PW:0]    r_count;

   // Storage is not reset; o_dout is forced to zero while empty instead.
   always_ff @(posedge CK) begin
      if (i_push) begin
         r_mem[r_wr] <= i_push_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wr <= r_wr + 1'b1;
         end
         if (i_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid = (r_count != '0);
   assign o_dout  = o_valid ? r_mem[r_rd] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/rom_fetch.sv
// Burst fetcher: reads len consecutive ROM words from base and streams them out in order.
// Latency: first word on dout two edges after the accepted start edge; then 1 word/cycle.
// Backpressure: address issue stalls when buffered + in-flight words would exceed DEPTH.
// Ports: CK clock, reset async active-low; start/base/len burst request (sampled in IDLE);
//        busy/done status; rom_A/rom_OE/rom_Q synchronous ROM port (1-cycle read);
//        dout/dout_valid/dout_ready consumer handshake.
module rom_fetch
   import rom_fetch_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          CK,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rom_A,
   output logic          rom_OE,
   input  logic [DW-1:0] rom_Q,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   input  logic          dout_ready
);

   localparam int          CW       = $clog2(DEPTH) + 1;
   localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [AW-1:0]   r_addr;      // next address to issue; drives rom_A directly
   logic [AW:0]     r_remain;    // addresses still to issue
   logic            r_inflight;  // word on rom_Q this cycle belongs to an issued address
   logic            r_done;

   logic            w_accept;
   logic            w_len_zero;
   logic            w_issue;
   logic            w_pop;
   logic            w_last;
   logic [CW-1:0]   w_count;
   logic [CW:0]     w_occ;

   // The done cycle still counts as busy, so a start there is ignored.
   assign w_accept   = start && (r_state == IDLE) && !r_done;
   assign w_len_zero = (len == '0);

   // Reserve a buffer slot for the word already in flight before issuing another.
   assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
   assign w_issue = (r_state == FETCH) && (r_remain != '0) && (w_occ < LP_DEPTH);

   assign w_pop  = dout_valid && dout_ready;
   // All addresses are issued in DRAIN; the burst ends when the only remaining word leaves.
   assign w_last = (r_state == DRAIN) && !r_inflight && (w_count == CW'(1)) && w_pop;

   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept && !w_len_zero)          w_state_nxt = FETCH;
         FETCH:   if (w_issue && (r_remain == (AW+1)'(1))) w_state_nxt = DRAIN;
         DRAIN:   if (w_last)                           w_state_nxt = IDLE;
         default:                                       w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         r_addr     <= '0;
         r_remain   <= '0;
         r_inflight <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         // ROM answers one cycle after the address, so capture trails issue by one edge.
         r_inflight <= w_issue;
         r_done     <= (w_accept && w_len_zero) || w_last;
         if (w_accept && !w_len_zero) begin
            r_addr   <= base;
            r_remain <= len;
         end else if (w_issue) begin
            r_addr   <= r_addr + 1'b1;   // wraps modulo 2^AW
            r_remain <= r_remain - 1'b1;
         end
      end
   end

   rom_fetch_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CK         (CK),
      .reset      (reset),
      .i_push     (r_inflight),
      .i_push_dat (rom_Q),
      .i_pop      (w_pop),
      .o_dout     (dout),
      .o_valid    (dout_valid),
      .o_count    (w_count)
   );

   assign busy   = (r_state != IDLE) || r_done;
   assign done   = r_done;
   assign rom_OE = busy;
   assign rom_A  = r_addr;

endmodule

// File: tb/tb_rom_fetch.sv
// Bench for rom_fetch: transaction-level reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: consumer ready held, stalled or randomized per phase.
module tb_rom_fetch;

   localparam int AW = 14;
   localparam int DW = 24;

   logic          CK = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic [AW-1:0] rom_A;
   logic          rom_OE;
   logic [DW-1:0] rom_Q;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;

   int errors = 0;
   int checks = 0;

   // Reference model state (owned by the compare process).
   logic [DW-1:0] q[$];
   int            m_left = 0;
   bit            m_busy = 1'b0;
   bit            m_done = 1'b0;
   int            xfers  = 0;
   bit            c_nb;
   bit            c_nd;
   logic [31:0]   c_want;

   bit rdy_rand = 1'b0;
   bit noise_en = 1'b0;
   int xs;
   int n;

   rom_fetch dut (
      .CK         (CK),
      .reset      (reset),
      .start      (start),
      .base       (base),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .rom_A      (rom_A),
      .rom_OE     (rom_OE),
      .rom_Q      (rom_Q),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   always #5 CK = ~CK;

   // Synchronous ROM: mem[i] = i*3, address registered on the rising edge.
   always @(posedge CK) rom_Q <= DW'(int'(rom_A) * 3);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   // Advance to just after the next rising edge and refresh randomized inputs.
   task automatic step();
      @(posedge CK);
      #1;
      if (rdy_rand) dout_ready = 1'($urandom_range(0, 1));
      if (noise_en) begin
         if (busy && !done) begin
            start = 1'($urandom_range(0, 1));
            base  = AW'($urandom);
            len   = (AW+1)'($urandom);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
      start = 1'b1;
      base  = b;
      len   = l;
      step();
      start = 1'b0;
   endtask

   // Bounded wait for the done pulse, then step past the done cycle.
   task automatic wait_done(input int budget, input string name);
      int k;
      k = 0;
      while (done !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      chk(name, 32'(done), 32'd1);
      step();
   endtask

   // Compare process: outputs checked mid-cycle, then the model advances over the coming edge.
   always @(negedge CK) begin
      if (!reset) begin
         chk("rst_ctl",  32'({busy, done, rom_OE, dout_valid}), 32'd0);
         chk("rst_dout", 32'(dout), 32'd0);
         chk("rst_romA", 32'(rom_A), 32'd0);
         q.delete();
         m_busy = 1'b0;
         m_done = 1'b0;
         m_left = 0;
      end else begin
         chk("busy",   32'(busy),   32'(m_busy));
         chk("done",   32'(done),   32'(m_done));
         chk("rom_OE", 32'(rom_OE), 32'(m_busy));
         if (!m_busy) chk("valid_idle", 32'(dout_valid), 32'd0);
         if (dout_valid) begin
            c_want = (q.size() > 0) ? 32'(q[0]) : 32'hFFFF_FFFF;
            chk("dout", 32'(dout), c_want);
         end
         c_nb = m_done ? 1'b0 : m_busy;
         c_nd = 1'b0;
         if (start && !m_busy) begin
            c_nb = 1'b1;
            if (len == '0) begin
               c_nd = 1'b1;
            end else begin
               for (int i = 0; i < int'(len); i++)
                  q.push_back(DW'(((int'(base) + i) % (1 << AW)) * 3));
               m_left = int'(len);
            end
         end
         if (dout_valid && dout_ready && q.size() > 0) begin
            void'(q.pop_front());
            xfers++;
            m_left--;
            if (m_left == 0) c_nd = 1'b1;
         end
         m_busy = c_nb;
         m_done = c_nd;
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; base = '0; len = '0; dout_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("por_ctl",  32'({busy, done, rom_OE, dout_valid}), 32'd0);
      chk("por_dout", 32'(dout), 32'd0);
      chk("por_romA", 32'(rom_A), 32'd0);
      repeat (3) @(posedge CK);
      #1 reset = 1'b1;
      step();

      // Basic burst with ready held high: exact cycle timing.
      dout_ready = 1'b1;
      do_start(14'h0010, 15'd4);
      chk("t1_c1_valid", 32'(dout_valid), 32'd0);
      chk("t1_c1_busy",  32'(busy), 32'd1);
      chk("t1_c1_romA",  32'(rom_A), 32'h0010);
      step();
      chk("t1_c2_valid", 32'(dout_valid), 32'd0);
      step();
      chk("t1_v0", 32'(dout_valid), 32'd1);
      chk("t1_w0", 32'(dout), 32'h30);
      step();
      chk("t1_v1", 32'(dout_valid), 32'd1);
      chk("t1_w1", 32'(dout), 32'h33);
      step();
      chk("t1_w2", 32'(dout), 32'h36);
      step();
      chk("t1_w3", 32'(dout), 32'h39);
      step();
      chk("t1_done",      32'(done), 32'd1);
      chk("t1_valid_end", 32'(dout_valid), 32'd0);
      step();
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_done_end", 32'(done), 32'd0);

      // Address wrap at the top of the ROM.
      do_start(14'h3FFE, 15'd4);
      step();
      step();
      chk("t2_w0", 32'(dout), 32'h00BFFA);
      wait_done(50, "t2_timeout");
      chk("t2_q_empty", 32'(q.size()), 32'd0);

      // Consumer stalled: buffer fills to DEPTH and issue stops.
      dout_ready = 1'b0;
      do_start(14'h0200, 15'd8);
      repeat (10) step();
      chk("t3_romA",  32'(rom_A), 32'h0204);
      chk("t3_valid", 32'(dout_valid), 32'd1);
      chk("t3_head",  32'(dout), 32'h000600);
      dout_ready = 1'b1;
      #1;
      chk("t3_rdy_valid", 32'(dout_valid), 32'd1);
      chk("t3_rdy_head",  32'(dout), 32'h000600);
      dout_ready = 1'b0;
      #1;
      dout_ready = 1'b1;
      wait_done(100, "t3_timeout");
      chk("t3_q_empty", 32'(q.size()), 32'd0);

      // Zero-length request.
      chk("t4_romA_before", 32'(rom_A), 32'h0208);
      do_start(14'h0555, 15'd0);
      chk("t4_done",  32'(done), 32'd1);
      chk("t4_busy",  32'(busy), 32'd1);
      chk("t4_valid", 32'(dout_valid), 32'd0);
      chk("t4_romA",  32'(rom_A), 32'h0208);
      step();
      chk("t4_done_end",  32'(done), 32'd0);
      chk("t4_busy_end",  32'(busy), 32'd0);
      chk("t4_valid_end", 32'(dout_valid), 32'd0);

      // Reset in the middle of a burst, then a fresh burst.
      xs = xfers;
      do_start(14'h0040, 15'd6);
      n = 0;
      while (xfers < xs + 2 && n < 20) begin
         step();
         n++;
      end
      chk("t5_progress", 32'(xfers - xs), 32'd2);
      reset = 1'b0;
      #1;
      chk("t5_rst_ctl",  32'({busy, done, rom_OE, dout_valid}), 32'd0);
      chk("t5_rst_dout", 32'(dout), 32'd0);
      chk("t5_rst_romA", 32'(rom_A), 32'd0);
      step();
      step();
      reset = 1'b1;
      step();
      step();
      chk("t5_idle_busy",  32'(busy), 32'd0);
      chk("t5_idle_valid", 32'(dout_valid), 32'd0);
      do_start(14'h0100, 15'd2);
      step();
      step();
      chk("t5_w0", 32'(dout), 32'h000300);
      wait_done(50, "t5_timeout");
      chk("t5_q_empty", 32'(q.size()), 32'd0);

      // Random short bursts under random backpressure.
      rdy_rand = 1'b1;
      for (int k = 0; k < 8; k++) begin
         do_start(AW'($urandom), (AW+1)'($urandom_range(1, 40)));
         wait_done(1000, "rand_timeout");
         chk("rand_q_empty", 32'(q.size()), 32'd0);
      end

      // Whole ROM, random backpressure, spurious starts during the burst.
      xs = xfers;
      noise_en = 1'b1;
      do_start(14'h0000, 15'h4000);
      wait_done(70000, "full_timeout");
      noise_en = 1'b0;
      start    = 1'b0;
      chk("full_count",   32'(xfers - xs), 32'd16384);
      chk("full_q_empty", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rom_fetch.md
ROM_FETCH -- requirements
Module: rom_fetch

Interface
REQ-001 Parameter AW, default 14, ROM address width.
REQ-002 Parameter DW, default 24, ROM data width.
REQ-003 Parameter DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-004 CK  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-006 start  input  1  request a burst; sampled only in IDLE.
REQ-007 base  input  AW  first ROM address of burst, sampled with start.
REQ-008 len  input  AW+1  word count, 0..2^AW, sampled with start.
REQ-009 busy  output  1  high from accepted start until done pulse (inclusive).
REQ-010 done  output  1  one-cycle pulse at burst completion.
REQ-011 rom_A  output  AW  address to ROM; ROM registers it on CK rising edge.
REQ-012 rom_OE  output  1  ROM output enable.
REQ-013 rom_Q  input  DW  ROM data; valid for the address rom_A held in the previous cycle.
REQ-014 dout  output  DW  buffered word to consumer.
REQ-015 dout_valid  output  1  dout holds a valid word.
REQ-016 dout_ready  input  1  consumer accepts; transfer when dout_valid & dout_ready at rising edge.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DRAIN; IDLE->FETCH on start with len!=0; FETCH->DRAIN after last address issued; DRAIN->IDLE on edge where last word is transferred.
REQ-018 start with len==0 in IDLE SHALL produce done pulse next cycle, no ROM access, busy high for that one cycle only.
REQ-019 start while busy SHALL be ignored; base/len not re-sampled.
REQ-020 Issue: in FETCH, one address per cycle on rom_A when remaining>0 and (buffer count + in-flight) < DEPTH; first issued address = base.
REQ-021 Addresses SHALL increment by 1 modulo 2^AW (0x3FFF wraps to 0x0000).
REQ-022 Latency: word for an address driven in cycle t SHALL be sampled from rom_Q at the rising edge ending cycle t+1 and written to the buffer.
REQ-023 In-flight counter (0..1) tracks issued-but-not-captured words; capture SHALL never overflow the buffer.
REQ-024 rom_OE SHALL be high whenever busy, low otherwise; rom_Q SHALL be sampled only for issued addresses.
REQ-025 rom_A SHALL hold its last value when not issuing.
REQ-026 Buffer is FIFO; dout = head entry, dout_valid = (count!=0); simultaneous push and pop SHALL keep count unchanged.
REQ-027 With dout_ready held high, throughput SHALL be one word per cycle after first word.
REQ-028 dout, dout_valid SHALL not depend combinationally on dout_ready.
REQ-029 done SHALL assert in the cycle after the last transfer edge; busy deasserts the cycle after done.
REQ-030 Words SHALL be output in address order, exactly len words, none dropped or duplicated under any dout_ready pattern.

Reset
REQ-031 On reset low, immediately: state=IDLE, rom_A=0, rom_OE=0, busy=0, done=0, dout_valid=0, dout=0, counters and buffer pointers=0.
REQ-032 Reset mid-burst SHALL abandon the burst; after release, block idles until a new start.

Structure
REQ-033 Shared package holds AW, DW defaults and the FSM state enumeration.
REQ-034 Output buffer SHALL be a sub-module named rom_fetch_fifo (DEPTH x DW, push/pop/count).

Verification
REQ-035 ROM mem[i]=i*3; start base=0x0010 len=4, dout_ready=1 -> dout 0x30,0x33,0x36,0x39 on 4 consecutive cycles, first dout_valid 2 cycles after start edge, done 1 cycle after last.
REQ-036 base=0x3FFE len=4 -> reads addresses 0x3FFE,0x3FFF,0x0000,0x0001 in order.
REQ-037 dout_ready=0 for 10 cycles, len=8 -> exactly 4 words buffered, rom_A stops advancing at base+4; release -> all 8 words in order.
REQ-038 len=0 -> done pulse next cycle, rom_OE never high for a read, dout_valid stays 0.
REQ-039 Assert reset after 2 of 6 words transferred -> all outputs 0 immediately; new start base=0x0100 len=2 completes correctly.
REQ-040 Random dout_ready (50%), len=16384 base=0 -> full ROM streamed in order, start pulses during burst ignored.
